accum_seq_ctrl: RTL and testbench

//  Sequencer for the Accumulator datapath (K-PE row-sum adder, 2-cycle in_valid->out_valid latency).
//  - Accepts a tile command (rows x cols output pixels).
//  - Gates PE-array results into the Accumulator with a valid/ready handshake.
//  - Tags each accumulated result with its (row,col) and flags the last one.
//  - Accumulator cannot stall, so issue is throttled by a downstream credit counter.

---
 rtl/accum_seq_ctrl_if.sv | 35 +++
 rtl/accum_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_accum_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_seq_ctrl_if.sv
// Tile command, PE issue, Accumulator result tagging and credit-return signals for accum_seq_ctrl.
// The master side drives commands and returns; the slave side is the sequencer.
interface accum_seq_ctrl_if #(
  parameter int ROW_BIT = 8,
  parameter int COL_BIT = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [ROW_BIT-1:0] cfg_rows;
  logic [COL_BIT-1:0] cfg_cols;
  logic               pe_valid;
  logic               pe_ready;
  logic               acc_in_valid;
  logic               acc_out_valid;
  logic               res_valid;
  logic [ROW_BIT-1:0] res_row;
  logic [COL_BIT-1:0] res_col;
  logic               res_last;
  logic               dn_ack;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cfg_valid, cfg_rows, cfg_cols, pe_valid, acc_out_valid, dn_ack,
    input  cfg_ready, pe_ready, acc_in_valid, res_valid, res_row, res_col,
           res_last, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_rows, cfg_cols, pe_valid, acc_out_valid, dn_ack,
    output cfg_ready, pe_ready, acc_in_valid, res_valid, res_row, res_col,
           res_last, busy, done, err
  );
endinterface

// File: rtl/accum_seq_ctrl.sv
// Accumulator sequencer: issues PE sums same-cycle (0 latency), tags results 2 cycles later.
// Issue stalls when downstream credits run out; the Accumulator itself never backpressures.
module accum_seq_ctrl #(
  parameter int ROW_BIT = 8,
  parameter int COL_BIT = 8,
  parameter int CREDITS = 4,
  parameter int CRD_BIT = 3
) (
  input logic          clk,
  input logic          rst,
  accum_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ROW_BIT-1:0] ROW_ONE = 1;
  localparam logic [COL_BIT-1:0] COL_ONE = 1;
  localparam logic [CRD_BIT-1:0] CRD_ONE = 1;
  localparam logic [CRD_BIT-1:0] CRD_MAX = CRD_BIT'(CREDITS);

  state_t             state;
  logic [ROW_BIT-1:0] rows_q, iss_row, rx_row;
  logic [COL_BIT-1:0] cols_q, iss_col, rx_col;
  logic [CRD_BIT-1:0] credits;
  logic               err_q, done_q, busy_q, cfg_rdy_q;

  logic pe_fire, rx_active, rx_fire, iss_col_wrap, rx_col_wrap, iss_last, rx_last;

  assign bus.pe_ready     = (state == RUN) && (credits != '0);
  assign pe_fire          = bus.pe_valid && bus.pe_ready;
  assign bus.acc_in_valid = pe_fire;

  assign iss_col_wrap = (iss_col == cols_q - COL_ONE);
  assign iss_last     = pe_fire && iss_col_wrap && (iss_row == rows_q - ROW_ONE);

  // Results only count while a tile is outstanding; anything else is a stray.
  assign rx_active   = (state == RUN) || (state == DRAIN);
  assign rx_fire     = bus.acc_out_valid && rx_active;
  assign rx_col_wrap = (rx_col == cols_q - COL_ONE);
  assign rx_last     = rx_fire && rx_col_wrap && (rx_row == rows_q - ROW_ONE);

  assign bus.res_valid = rx_fire;
  assign bus.res_row   = rx_row;
  assign bus.res_col   = rx_col;
  assign bus.res_last  = rx_last;
  assign bus.cfg_ready = cfg_rdy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      iss_row   <= '0;
      iss_col   <= '0;
      rx_row    <= '0;
      rx_col    <= '0;
      credits   <= CRD_MAX;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_rdy_q <= 1'b1;
    end else begin
      done_q <= 1'b0;

      // Simultaneous issue and return cancel out; a return with nothing outstanding is an error.
      if (pe_fire && !bus.dn_ack) begin
        credits <= credits - CRD_ONE;
      end else if (!pe_fire && bus.dn_ack) begin
        if (credits == CRD_MAX) err_q <= 1'b1;
        else                    credits <= credits + CRD_ONE;
      end

      if (bus.acc_out_valid && !rx_active) err_q <= 1'b1;

      if (pe_fire) begin
        if (iss_col_wrap) begin
          iss_col <= '0;
          iss_row <= iss_row + ROW_ONE;
        end else begin
          iss_col <= iss_col + COL_ONE;
        end
      end

      if (rx_fire) begin
        if (rx_col_wrap) begin
          rx_col <= '0;
          rx_row <= rx_row + ROW_ONE;
        end else begin
          rx_col <= rx_col + COL_ONE;
        end
      end

      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            rows_q    <= bus.cfg_rows;
            cols_q    <= bus.cfg_cols;
            iss_row   <= '0;
            iss_col   <= '0;
            rx_row    <= '0;
            rx_col    <= '0;
            cfg_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
            if (bus.cfg_rows != '0 && bus.cfg_cols != '0) begin
              state <= RUN;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (iss_last) state <= DRAIN;
        end
        DRAIN: begin
          if (rx_last) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          cfg_rdy_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Bench for accum_seq_ctrl: directed vector table, corner sequences and a randomized run
// against a tile-level reference model; a 2-cycle delay line stands in for the Accumulator.
module tb_accum_seq_ctrl;

  localparam int RB = 8;
  localparam int CB = 8;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accum_seq_ctrl_if #(.ROW_BIT(RB), .COL_BIT(CB)) bus ();

  accum_seq_ctrl #(.ROW_BIT(RB), .COL_BIT(CB), .CREDITS(CREDITS), .CRD_BIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Accumulator stand-in and test-forced stray result.
  bit d1, d2, force_aov;

  // Tile-level reference model.
  bit m_known, m_active, m_done, m_err;
  int m_issued, m_recv, m_total, m_cols, m_credits;

  // DUT outputs seen at the last sample point.
  logic obs_cfg_ready, obs_prdy, obs_aiv, obs_rv, obs_last, obs_busy, obs_done, obs_err;
  int   obs_row, obs_col;

  typedef struct {
    bit cv; int rows; int cols; bit pv; bit ack;
    bit e_prdy; bit e_aiv; bit e_rv; int e_row; int e_col; bit e_last; bit e_busy; bit e_done;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    bit e_prdy, e_aiv, e_rv, e_last, aiv;
    int e_row, e_col;
    bus.acc_out_valid = d2 | force_aov;
    @(negedge clk);
    obs_cfg_ready = bus.cfg_ready;
    obs_prdy = bus.pe_ready;
    obs_aiv  = bus.acc_in_valid;
    obs_rv   = bus.res_valid;
    obs_row  = int'(bus.res_row);
    obs_col  = int'(bus.res_col);
    obs_last = bus.res_last;
    obs_busy = bus.busy;
    obs_done = bus.done;
    obs_err  = bus.err;

    e_prdy = m_active && (m_issued < m_total) && (m_credits > 0);
    e_aiv  = e_prdy && bus.pe_valid;
    e_rv   = bus.acc_out_valid && m_active;
    e_last = e_rv && (m_recv == m_total - 1);
    e_row  = (m_cols != 0) ? m_recv / m_cols : 0;
    e_col  = (m_cols != 0) ? m_recv % m_cols : 0;

    if (m_known) begin
      chk("cfg_ready", obs_cfg_ready, !m_active && !m_done);
      chk("busy", obs_busy, m_active || m_done);
      chk("done", obs_done, m_done);
      chk("pe_ready", obs_prdy, e_prdy);
      chk("acc_in_valid", obs_aiv, e_aiv);
      chk("res_valid", obs_rv, e_rv);
      chk("res_last", obs_last, e_last);
      chk("err", obs_err, m_err);
      if (e_rv) begin
        chk("res_row", obs_row, e_row);
        chk("res_col", obs_col, e_col);
      end
    end
    aiv = bus.acc_in_valid;

    if (rst) begin
      m_known = 1; m_active = 0; m_done = 0; m_err = 0;
      m_issued = 0; m_recv = 0; m_total = 0; m_cols = 0; m_credits = CREDITS;
    end else if (m_known) begin
      if (bus.dn_ack && !e_aiv && m_credits == CREDITS) m_err = 1;
      if (bus.acc_out_valid && !m_active) m_err = 1;
      if (e_aiv && !bus.dn_ack) m_credits--;
      else if (!e_aiv && bus.dn_ack && m_credits < CREDITS) m_credits++;
      if (e_aiv) m_issued++;
      if (e_rv) m_recv++;
      if (m_done) begin
        m_done = 0;
      end else if (!m_active && bus.cfg_valid) begin
        m_total = int'(bus.cfg_rows) * int'(bus.cfg_cols);
        m_cols = int'(bus.cfg_cols);
        m_issued = 0; m_recv = 0;
        if (m_total == 0) m_done = 1;
        else              m_active = 1;
      end else if (m_active && e_rv && m_recv == m_total) begin
        m_active = 0; m_done = 1;
      end
    end

    @(posedge clk);
    #1;
    if (rst) begin d1 = 0; d2 = 0; end
    else begin d2 = d1; d1 = aiv; end
  endtask

  task automatic idle_inputs();
    bus.cfg_valid = 0; bus.cfg_rows = '0; bus.cfg_cols = '0;
    bus.pe_valid = 0; bus.dn_ack = 0;
  endtask

  task automatic restore_credits();
    for (int k = 0; k < 8; k++) begin
      bus.dn_ack = (m_credits < CREDITS);
      step();
    end
    bus.dn_ack = 0;
  endtask

  initial begin
    int fires, lat, tiles;
    bit seen, any_aiv;

    // rows=2 cols=3, credits run out after 4 issues, then a 2-cycle credit return.
    tv[0]  = '{1, 2, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0};
    tv[2]  = '{0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0};
    tv[3]  = '{0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 1, 0};
    tv[4]  = '{0, 0, 0, 1, 0,  1, 1, 1, 0, 1, 0, 1, 0};
    tv[5]  = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 2, 0, 1, 0};
    tv[6]  = '{0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 1, 0};
    tv[7]  = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0};
    tv[8]  = '{0, 0, 0, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0};
    tv[9]  = '{0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0};
    tv[10] = '{0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 0, 1, 0};
    tv[11] = '{0, 0, 0, 1, 0,  0, 0, 1, 1, 2, 1, 1, 0};
    tv[12] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1};
    tv[13] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};

    d1 = 0; d2 = 0; force_aov = 0; m_known = 0;
    idle_inputs();
    rst = 1;
    step();
    rst = 0;

    step();
    chk("rst_cfg_ready", obs_cfg_ready, 1);
    chk("rst_pe_ready", obs_prdy, 0);
    chk("rst_res_valid", obs_rv, 0);
    chk("rst_busy", obs_busy, 0);
    chk("rst_err", obs_err, 0);

    for (int i = 0; i < 14; i++) begin
      bus.cfg_valid = tv[i].cv;
      bus.cfg_rows  = RB'(tv[i].rows);
      bus.cfg_cols  = CB'(tv[i].cols);
      bus.pe_valid  = tv[i].pv;
      bus.dn_ack    = tv[i].ack;
      step();
      chk($sformatf("tv%0d_pe_ready", i), obs_prdy, tv[i].e_prdy);
      chk($sformatf("tv%0d_acc_in_valid", i), obs_aiv, tv[i].e_aiv);
      chk($sformatf("tv%0d_res_valid", i), obs_rv, tv[i].e_rv);
      chk($sformatf("tv%0d_res_last", i), obs_last, tv[i].e_last);
      chk($sformatf("tv%0d_busy", i), obs_busy, tv[i].e_busy);
      chk($sformatf("tv%0d_done", i), obs_done, tv[i].e_done);
      if (tv[i].e_rv) begin
        chk($sformatf("tv%0d_res_row", i), obs_row, tv[i].e_row);
        chk($sformatf("tv%0d_res_col", i), obs_col, tv[i].e_col);
      end
    end
    idle_inputs();
    restore_credits();

    // Empty tile: accepted, completes without issuing anything.
    bus.cfg_valid = 1; bus.cfg_rows = 8'd0; bus.cfg_cols = 8'd5; bus.pe_valid = 1;
    step();
    bus.cfg_valid = 0;
    seen = 0; any_aiv = 0; lat = -1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (obs_aiv) any_aiv = 1;
      if (obs_done && !seen) begin seen = 1; lat = k; end
    end
    chk("t3_done_seen", seen, 1);
    chk("t3_done_latency", lat, 1);
    chk("t3_no_issue", any_aiv, 0);
    chk("t3_err", obs_err, 0);
    idle_inputs();

    // Reset in the middle of a tile, then a fresh tile must see full credits.
    bus.cfg_valid = 1; bus.cfg_rows = 8'd2; bus.cfg_cols = 8'd3; bus.pe_valid = 1;
    step();
    bus.cfg_valid = 0;
    for (int k = 0; k < 3; k++) step();
    rst = 1;
    step();
    rst = 0;
    bus.pe_valid = 0;
    step();
    chk("t5_cfg_ready", obs_cfg_ready, 1);
    chk("t5_busy", obs_busy, 0);
    chk("t5_done", obs_done, 0);
    bus.cfg_valid = 1; bus.cfg_rows = 8'd2; bus.cfg_cols = 8'd3; bus.pe_valid = 1;
    step();
    bus.cfg_valid = 0;
    fires = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (obs_aiv) fires++;
    end
    chk("t5_fires_on_full_credit", fires, CREDITS);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      bus.dn_ack = (m_credits < CREDITS);
      step();
      if (obs_done) seen = 1;
    end
    chk("t5_tile_done", seen, 1);
    idle_inputs();
    step();
    restore_credits();

    // Stray credit return and stray result, each sets the sticky error.
    bus.dn_ack = 1;
    step();
    bus.dn_ack = 0;
    step();
    chk("t6_err_ack", obs_err, 1);
    for (int k = 0; k < 3; k++) step();
    chk("t6_err_sticky", obs_err, 1);
    rst = 1;
    step();
    rst = 0;
    step();
    chk("t6_err_cleared", obs_err, 0);
    force_aov = 1;
    step();
    force_aov = 0;
    step();
    chk("t6_err_stray_result", obs_err, 1);

    rst = 1;
    step();
    rst = 0;

    tiles = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.cfg_valid = ($urandom_range(0, 3) == 0);
      bus.cfg_rows  = RB'($urandom_range(0, 3));
      bus.cfg_cols  = CB'($urandom_range(0, 4));
      bus.pe_valid  = ($urandom_range(0, 2) != 0);
      bus.dn_ack    = (m_credits < CREDITS) && ($urandom_range(0, 1) == 1);
      step();
      if (obs_done) tiles++;
    end
    chk("rand_progress", tiles > 20, 1);
    chk("rand_err", obs_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
